// File: rtl/qdr_resp_pkg.sv
// qdr_resp_pkg: shared definitions for the QDR block-RAM responder.
// Holds the default user-port widths, the calibration state encoding and a
// clog2 helper used to size the calibration counter.
package qdr_resp_pkg;

  localparam int unsigned QDR_DATA_WIDTH_DEF = 18;
  localparam int unsigned QDR_BW_WIDTH_DEF   = 2;

  localparam int unsigned USER_DW  = 2 * QDR_DATA_WIDTH_DEF;
  localparam int unsigned USER_BEW = 2 * QDR_BW_WIDTH_DEF;
  localparam int unsigned LANE_W   = QDR_DATA_WIDTH_DEF / QDR_BW_WIDTH_DEF;

  typedef enum logic [1:0] {
    CAL  = 2'd0,
    RDY  = 2'd1,
    FAIL = 2'd2
  } qdr_state_e;

  // Bits needed to count 0..value-1, never less than 1.
  function automatic int unsigned qdr_clog2(input int unsigned value);
    int unsigned w;
    w = 1;
    for (int unsigned i = 1; i < 32; i++) begin
      if ((32'd1 << i) < value) w = i + 1;
    end
    return w;
  endfunction

endpackage

// File: rtl/qdr_resp_rd_pipe.sv
// qdr_resp_rd_pipe: valid + data delay line of DEPTH stages.
// Ports:
//   i_clk, i_rst    clock, asynchronous active-high reset (valid bits only)
//   i_vld, i_data   stage-0 input
//   o_vld, o_data   output after DEPTH clock edges
// Data registers load only when their incoming valid is set, so o_data keeps
// the last word delivered.
module qdr_resp_rd_pipe #(
  parameter int unsigned DEPTH = 9,
  parameter int unsigned WIDTH = 36
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_vld,
  input  logic [WIDTH-1:0] i_data,
  output logic             o_vld,
  output logic [WIDTH-1:0] o_data
);

  logic [DEPTH-1:0] r_vld;
  logic [WIDTH-1:0] r_data [DEPTH];
  logic [DEPTH-1:0] w_vld_in;
  logic [WIDTH-1:0] w_data_in [DEPTH];

  always_comb begin
    w_vld_in     = '0;
    w_vld_in[0]  = i_vld;
    w_data_in[0] = i_data;
    for (int i = 1; i < DEPTH; i++) begin
      w_vld_in[i]  = r_vld[i-1];
      w_data_in[i] = r_data[i-1];
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_vld <= '0;
    end else begin
      r_vld <= w_vld_in;
    end
  end

  always_ff @(posedge i_clk) begin
    for (int i = 0; i < DEPTH; i++) begin
      if (w_vld_in[i]) r_data[i] <= w_data_in[i];
    end
  end

  assign o_vld  = r_vld[DEPTH-1];
  assign o_data = r_data[DEPTH-1];

endmodule

// File: rtl/qdr_bram_responder.sv
// qdr_bram_responder: block-RAM stand-in for the QDR controller user port.
// Ports:
//   qdr_clk, qdr_reset             clock, asynchronous active-high reset
//   master_addr                    request address (high bits alias)
//   master_wr_strb/_data/_be       single-cycle write, per-lane enables
//   master_rd_strb                 single-cycle read request
//   master_rd_data, master_rd_dvld read return, RD_LATENCY after the strobe
//   phy_rdy, cal_fail              modelled calibration result
module qdr_bram_responder
  import qdr_resp_pkg::*;
#(
  parameter int unsigned QDR_DATA_WIDTH = QDR_DATA_WIDTH_DEF,
  parameter int unsigned QDR_BW_WIDTH   = QDR_BW_WIDTH_DEF,
  parameter int unsigned QDR_ADDR_WIDTH = 22,
  parameter int unsigned MEM_ADDR_WIDTH = 10,
  parameter int unsigned RD_LATENCY     = 10,
  parameter int unsigned CAL_CYCLES     = 64,
  parameter bit          FORCE_CAL_FAIL = 1'b0
) (
  input  logic                        qdr_clk,
  input  logic                        qdr_reset,
  input  logic [QDR_ADDR_WIDTH-1:0]   master_addr,
  input  logic                        master_wr_strb,
  input  logic [2*QDR_DATA_WIDTH-1:0] master_wr_data,
  input  logic [2*QDR_BW_WIDTH-1:0]   master_wr_be,
  input  logic                        master_rd_strb,
  output logic [2*QDR_DATA_WIDTH-1:0] master_rd_data,
  output logic                        master_rd_dvld,
  output logic                        phy_rdy,
  output logic                        cal_fail
);

  localparam int unsigned DW    = 2 * QDR_DATA_WIDTH;
  localparam int unsigned BEW   = 2 * QDR_BW_WIDTH;
  localparam int unsigned LW    = QDR_DATA_WIDTH / QDR_BW_WIDTH;
  localparam int unsigned CNT_W = qdr_clog2(CAL_CYCLES);
  localparam int unsigned WORDS = 2 ** MEM_ADDR_WIDTH;

  qdr_state_e         r_state;
  logic [CNT_W-1:0]   r_cal_cnt;
  logic               r_phy_rdy;
  logic               r_cal_fail;

  logic [DW-1:0]      r_mem [WORDS];
  logic [DW-1:0]      r_ram_q;
  logic               r_ram_vld;
  logic               r_rd_seen;

  logic [MEM_ADDR_WIDTH-1:0] w_mem_addr;
  logic               w_wr_en;
  logic               w_rd_en;
  logic               w_pipe_vld;
  logic [DW-1:0]      w_pipe_data;

  assign w_mem_addr = master_addr[MEM_ADDR_WIDTH-1:0];
  // Gating with qdr_reset drops a strobe at the edge where reset asserts.
  assign w_wr_en    = r_phy_rdy & master_wr_strb & ~qdr_reset;
  assign w_rd_en    = r_phy_rdy & master_rd_strb & ~qdr_reset;

  if (QDR_ADDR_WIDTH > MEM_ADDR_WIDTH) begin : g_alias
    logic w_unused_addr_hi;
    assign w_unused_addr_hi = ^master_addr[QDR_ADDR_WIDTH-1:MEM_ADDR_WIDTH];
  end

  // Calibration FSM; outputs are registered alongside the state.
  always_ff @(posedge qdr_clk or posedge qdr_reset) begin
    if (qdr_reset) begin
      r_state    <= CAL;
      r_cal_cnt  <= '0;
      r_phy_rdy  <= 1'b0;
      r_cal_fail <= 1'b0;
    end else begin
      case (r_state)
        CAL: begin
          if (r_cal_cnt == CNT_W'(CAL_CYCLES - 1)) begin
            if (FORCE_CAL_FAIL) begin
              r_state    <= FAIL;
              r_cal_fail <= 1'b1;
            end else begin
              r_state   <= RDY;
              r_phy_rdy <= 1'b1;
            end
          end else begin
            r_cal_cnt <= r_cal_cnt + CNT_W'(1);
          end
        end
        RDY:     r_state <= RDY;
        FAIL:    r_state <= FAIL;
        default: r_state <= CAL;
      endcase
    end
  end

  // Backing RAM: not reset; read-before-write on a same-address collision.
  always_ff @(posedge qdr_clk) begin
    if (w_wr_en) begin
      for (int i = 0; i < BEW; i++) begin
        if (master_wr_be[i]) r_mem[w_mem_addr][i*LW +: LW] <= master_wr_data[i*LW +: LW];
      end
    end
    if (w_rd_en) r_ram_q <= r_mem[w_mem_addr];
  end

  always_ff @(posedge qdr_clk or posedge qdr_reset) begin
    if (qdr_reset) begin
      r_ram_vld <= 1'b0;
      r_rd_seen <= 1'b0;
    end else begin
      r_ram_vld <= w_rd_en;
      if (w_pipe_vld) r_rd_seen <= 1'b1;
    end
  end

  // RAM output register is the first of RD_LATENCY registers.
  qdr_resp_rd_pipe #(
    .DEPTH (RD_LATENCY - 1),
    .WIDTH (DW)
  ) u_rd_pipe (
    .i_clk  (qdr_clk),
    .i_rst  (qdr_reset),
    .i_vld  (r_ram_vld),
    .i_data (r_ram_q),
    .o_vld  (w_pipe_vld),
    .o_data (w_pipe_data)
  );

  // Pipe data registers are not reset; present zero until the first return.
  assign master_rd_data = (r_rd_seen | w_pipe_vld) ? w_pipe_data : '0;
  assign master_rd_dvld = w_pipe_vld;
  assign phy_rdy        = r_phy_rdy;
  assign cal_fail       = r_cal_fail;

endmodule

// File: tb/tb_qdr_bram_responder.sv
module tb_qdr_bram_responder;

  logic        clk = 1'b0;
  logic        rst;
  logic [21:0] addr;
  logic        wr_strb;
  logic [35:0] wr_data;
  logic [3:0]  wr_be;
  logic        rd_strb;
  logic [35:0] rd_data;
  logic        dvld;
  logic        phy_rdy;
  logic        cal_fail;
  logic [35:0] f_rd_data;
  logic        f_dvld;
  logic        f_phy_rdy;
  logic        f_cal_fail;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int f_dvld_cnt = 0;
  logic [35:0] rx_data [$];
  int          rx_cyc  [$];

  always #5 clk = ~clk;

  qdr_bram_responder #(
    .RD_LATENCY     (10),
    .CAL_CYCLES     (64),
    .FORCE_CAL_FAIL (1'b0)
  ) dut (
    .qdr_clk        (clk),
    .qdr_reset      (rst),
    .master_addr    (addr),
    .master_wr_strb (wr_strb),
    .master_wr_data (wr_data),
    .master_wr_be   (wr_be),
    .master_rd_strb (rd_strb),
    .master_rd_data (rd_data),
    .master_rd_dvld (dvld),
    .phy_rdy        (phy_rdy),
    .cal_fail       (cal_fail)
  );

  qdr_bram_responder #(
    .RD_LATENCY     (10),
    .CAL_CYCLES     (64),
    .FORCE_CAL_FAIL (1'b1)
  ) dut_fail (
    .qdr_clk        (clk),
    .qdr_reset      (rst),
    .master_addr    (addr),
    .master_wr_strb (wr_strb),
    .master_wr_data (wr_data),
    .master_wr_be   (wr_be),
    .master_rd_strb (rd_strb),
    .master_rd_data (f_rd_data),
    .master_rd_dvld (f_dvld),
    .phy_rdy        (f_phy_rdy),
    .cal_fail       (f_cal_fail)
  );

  always @(posedge clk) cyc = cyc + 1;

  always @(negedge clk) begin
    if (dvld === 1'b1) begin
      rx_data.push_back(rd_data);
      rx_cyc.push_back(cyc);
    end
    if (f_dvld !== 1'b0) f_dvld_cnt++;
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic wr(input logic [21:0] a, input logic [35:0] d, input logic [3:0] be);
    addr = a; wr_data = d; wr_be = be; wr_strb = 1'b1;
    tick();
    wr_strb = 1'b0;
  endtask

  task automatic rd(input logic [21:0] a);
    addr = a; rd_strb = 1'b1;
    tick();
    rd_strb = 1'b0;
  endtask

  task automatic wait_rx(input int n);
    for (int k = 0; k < 40 && rx_data.size() < n; k++) tick();
  endtask

  function automatic logic [35:0] pat(input int i);
    return 36'hA_0000_0000 + 36'(i * 'h111);
  endfunction

  task automatic test_reset();
    tick(); tick();
    total++; if (phy_rdy !== 1'b0) begin bad++; $display("FAIL reset_phy_rdy got=%b exp=0", phy_rdy); end
    total++; if (cal_fail !== 1'b0) begin bad++; $display("FAIL reset_cal_fail got=%b exp=0", cal_fail); end
    total++; if (dvld !== 1'b0) begin bad++; $display("FAIL reset_dvld got=%b exp=0", dvld); end
    total++; if (rd_data !== 36'h0) begin bad++; $display("FAIL reset_rd_data got=%h exp=0", rd_data); end
    total++; if (f_cal_fail !== 1'b0) begin bad++; $display("FAIL reset_f_cal_fail got=%b exp=0", f_cal_fail); end
  endtask

  // Release reset; reads strobed during CAL must be dropped.
  task automatic test_calibration();
    rx_data.delete(); rx_cyc.delete();
    rst = 1'b0;
    for (int t = 1; t <= 64; t++) begin
      rd_strb = (t <= 10); addr = 22'(t);
      tick();
      if (t == 63) begin
        total++; if (phy_rdy !== 1'b0) begin bad++; $display("FAIL cal_early_rdy got=%b exp=0", phy_rdy); end
        total++; if (f_cal_fail !== 1'b0) begin bad++; $display("FAIL cal_early_fail got=%b exp=0", f_cal_fail); end
      end
    end
    rd_strb = 1'b0;
    total++; if (phy_rdy !== 1'b1) begin bad++; $display("FAIL cal_rdy got=%b exp=1", phy_rdy); end
    total++; if (cal_fail !== 1'b0) begin bad++; $display("FAIL cal_no_fail got=%b exp=0", cal_fail); end
    total++; if (f_cal_fail !== 1'b1) begin bad++; $display("FAIL cal_forced_fail got=%b exp=1", f_cal_fail); end
    total++; if (f_phy_rdy !== 1'b0) begin bad++; $display("FAIL cal_forced_rdy got=%b exp=0", f_phy_rdy); end
    total++; if (rx_data.size() != 0) begin bad++; $display("FAIL cal_dropped_reads got=%0d exp=0", rx_data.size()); end
  endtask

  task automatic test_back_to_back();
    int issue;
    for (int i = 0; i < 16; i++) wr(22'(i), pat(i), 4'hF);
    rx_data.delete(); rx_cyc.delete();
    issue = cyc;
    for (int i = 0; i < 16; i++) begin
      addr = 22'(i); rd_strb = 1'b1;
      tick();
    end
    rd_strb = 1'b0;
    wait_rx(16);
    total++; if (rx_data.size() != 16) begin bad++; $display("FAIL b2b_count got=%0d exp=16", rx_data.size()); end
    for (int i = 0; i < rx_data.size(); i++) begin
      total++;
      if (rx_data[i] !== pat(i) || rx_cyc[i] != issue + 10 + i) begin
        bad++;
        $display("FAIL b2b_item%0d got=%h@%0d exp=%h@%0d", i, rx_data[i], rx_cyc[i], pat(i), issue + 10 + i);
      end
    end
  endtask

  task automatic test_same_cycle();
    rx_data.delete(); rx_cyc.delete();
    addr = 22'd3; wr_data = 36'h3_3333_3333; wr_be = 4'hF; wr_strb = 1'b1; rd_strb = 1'b1;
    tick();
    wr_strb = 1'b0;
    tick();
    rd_strb = 1'b0;
    wait_rx(2);
    total++; if (rx_data.size() != 2) begin bad++; $display("FAIL same_count got=%0d exp=2", rx_data.size()); end
    else begin
      total++; if (rx_data[0] !== pat(3)) begin bad++; $display("FAIL same_old got=%h exp=%h", rx_data[0], pat(3)); end
      total++; if (rx_data[1] !== 36'h3_3333_3333) begin bad++; $display("FAIL same_new got=%h exp=333333333", rx_data[1]); end
    end
  endtask

  task automatic test_write_read();
    int issue;
    wr(22'd5, 36'h1_2345_6789, 4'hF);
    rx_data.delete(); rx_cyc.delete();
    issue = cyc;
    rd(22'd5);
    wait_rx(1);
    for (int k = 0; k < 5; k++) tick();
    total++; if (rx_data.size() != 1) begin bad++; $display("FAIL wr_rd_count got=%0d exp=1", rx_data.size()); end
    else begin
      total++; if (rx_cyc[0] - issue != 10) begin bad++; $display("FAIL wr_rd_latency got=%0d exp=10", rx_cyc[0] - issue); end
      total++; if (rx_data[0] !== 36'h1_2345_6789) begin bad++; $display("FAIL wr_rd_data got=%h exp=123456789", rx_data[0]); end
    end
    total++; if (rd_data !== 36'h1_2345_6789 || dvld !== 1'b0) begin
      bad++; $display("FAIL wr_rd_hold got=%h/%b exp=123456789/0", rd_data, dvld);
    end
  endtask

  task automatic test_byte_enable();
    rx_data.delete(); rx_cyc.delete();
    wr(22'd7, 36'hF_FFFF_FFFF, 4'hF);
    wr(22'd7, 36'h0, 4'b0101);
    rd(22'd7);
    wr(22'd7, 36'h0, 4'b0000);
    rd(22'd7);
    wait_rx(2);
    total++; if (rx_data.size() != 2) begin bad++; $display("FAIL be_count got=%0d exp=2", rx_data.size()); end
    else begin
      total++; if (rx_data[0] !== 36'hF_F803_FE00) begin bad++; $display("FAIL be_lanes got=%h exp=ff803fe00", rx_data[0]); end
      total++; if (rx_data[1] !== 36'hF_F803_FE00) begin bad++; $display("FAIL be_none got=%h exp=ff803fe00", rx_data[1]); end
    end
  endtask

  task automatic test_reset_inflight();
    rx_data.delete(); rx_cyc.delete();
    for (int i = 0; i < 4; i++) begin
      addr = 22'(i); rd_strb = 1'b1;
      tick();
    end
    rd_strb = 1'b0;
    rst = 1'b1;
    #1;
    total++; if (phy_rdy !== 1'b0) begin bad++; $display("FAIL rst_async_rdy got=%b exp=0", phy_rdy); end
    tick(); tick(); tick();
    total++; if (f_cal_fail !== 1'b0) begin bad++; $display("FAIL rst_f_cal_fail got=%b exp=0", f_cal_fail); end
    rst = 1'b0;
    for (int t = 1; t <= 64; t++) begin
      wr_strb = (t <= 8); rd_strb = (t <= 8);
      addr = 22'd5; wr_data = 36'h0_DEAD_BEEF; wr_be = 4'hF;
      tick();
      if (t == 63) begin
        total++; if (phy_rdy !== 1'b0) begin bad++; $display("FAIL recal_early got=%b exp=0", phy_rdy); end
      end
    end
    wr_strb = 1'b0; rd_strb = 1'b0;
    total++; if (phy_rdy !== 1'b1) begin bad++; $display("FAIL recal_rdy got=%b exp=1", phy_rdy); end
    total++; if (f_cal_fail !== 1'b1) begin bad++; $display("FAIL recal_f_fail got=%b exp=1", f_cal_fail); end
    for (int k = 0; k < 15; k++) tick();
    total++; if (rx_data.size() != 0) begin bad++; $display("FAIL rst_no_dvld got=%0d exp=0", rx_data.size()); end
    rd(22'd5);
    wait_rx(1);
    total++; if (rx_data.size() != 1 || rx_data[0] !== 36'h1_2345_6789) begin
      bad++; $display("FAIL rst_ram_kept got=%0d/%h exp=1/123456789", rx_data.size(), rx_data[0]);
    end
  endtask

  task automatic test_alias();
    rx_data.delete(); rx_cyc.delete();
    wr(22'd5 + 22'd1024, 36'hA_5A5A_5A5A, 4'hF);
    rd(22'd5);
    rd(22'd5 + 22'd2048);
    wait_rx(2);
    total++; if (rx_data.size() != 2) begin bad++; $display("FAIL alias_count got=%0d exp=2", rx_data.size()); end
    else begin
      total++; if (rx_data[0] !== 36'hA_5A5A_5A5A) begin bad++; $display("FAIL alias_base got=%h exp=a5a5a5a5a", rx_data[0]); end
      total++; if (rx_data[1] !== 36'hA_5A5A_5A5A) begin bad++; $display("FAIL alias_hi got=%h exp=a5a5a5a5a", rx_data[1]); end
    end
  endtask

  initial begin
    rst = 1'b1; addr = '0; wr_strb = 1'b0; wr_data = '0; wr_be = '0; rd_strb = 1'b0;
    test_reset();
    test_calibration();
    test_back_to_back();
    test_same_cycle();
    test_write_read();
    test_byte_enable();
    test_reset_inflight();
    test_alias();
    total++; if (f_dvld_cnt != 0) begin bad++; $display("FAIL fail_dut_dvld got=%0d exp=0", f_dvld_cnt); end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
